serial_packet_rx: RTL and testbench

- Parametrised serial-link packet receiver; successor to the fixed 2-bit-address / 4-bit-data receiver on the point-to-point link.
- Deserialises start bit + address + data + optional even-parity bit, and filters on a maskable address.
- Presents accepted packets through a one-entry valid/ready holding register, with drop and parity-error reporting.
- Sits between the link wire and a consumer such as a register file write port or a FIFO.

---
 rtl/serial_packet_rx.sv | 134 +++++++++++++
 tb/tb_serial_packet_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_packet_rx.sv
// rtl/serial_packet_rx.sv - serial packet receiver with address filter, even parity and one-entry output holding register
module serial_packet_rx #(
   parameter int ADDR_W    = 2,
   parameter int DATA_W    = 4,
   parameter int PARITY_EN = 1,
   parameter int CNT_W     = 8
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              link,
   input  logic [ADDR_W-1:0] rx_addr,
   input  logic [ADDR_W-1:0] rx_mask,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              perr,
   output logic              ovf,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int PKT_W  = ADDR_W + DATA_W;
   localparam int MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int BCNT_W = $clog2(MAX_W + 1);
   localparam logic [BCNT_W-1:0] ADDR_LAST = BCNT_W'(ADDR_W - 1);
   localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_PAR} state_t;

   state_t            state, state_nxt;
   logic [BCNT_W-1:0] bit_cnt, bit_cnt_nxt;
   logic [PKT_W-1:0]  shift;
   logic [PKT_W-1:0]  pkt;
   logic              par_acc;
   logic              done, par_ok, addr_match, accept, load, drop, bad_par, take;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      case (state)
         S_IDLE: begin
            if (link) begin
               state_nxt   = S_ADDR;
               bit_cnt_nxt = '0;
            end
         end
         S_ADDR: begin
            if (bit_cnt == ADDR_LAST) begin
               state_nxt   = S_DATA;
               bit_cnt_nxt = '0;
            end else begin
               bit_cnt_nxt = bit_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_cnt == DATA_LAST) begin
               state_nxt   = (PARITY_EN != 0) ? S_PAR : S_IDLE;
               bit_cnt_nxt = '0;
            end else begin
               bit_cnt_nxt = bit_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
         end
      endcase
   end

   // Completion is decided on the edge sampling the final bit, so the last
   // field bit or parity bit is taken straight from link rather than the shifter.
   always_comb begin
      done       = ((state == S_DATA) && (bit_cnt == DATA_LAST) && (PARITY_EN == 0)) ||
                   (state == S_PAR);
      pkt        = (state == S_PAR) ? shift : {shift[PKT_W-2:0], link};
      par_ok     = (PARITY_EN == 0) ? 1'b1 : ~(par_acc ^ link);
      addr_match = (((pkt[PKT_W-1 -: ADDR_W] ^ rx_addr) & rx_mask) == '0);
      accept     = done && par_ok && addr_match;
      take       = out_valid && out_ready;
      load       = accept && (!out_valid || out_ready);
      drop       = accept && out_valid && !out_ready;
      bad_par    = done && !par_ok;
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         shift     <= '0;
         par_acc   <= 1'b0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         perr      <= 1'b0;
         ovf       <= 1'b0;
         drop_cnt  <= '0;
         err_cnt   <= '0;
      end else begin
         if (state == S_IDLE) begin
            shift   <= '0;
            par_acc <= 1'b0;
         end else if ((state == S_ADDR) || (state == S_DATA)) begin
            shift   <= {shift[PKT_W-2:0], link};
            par_acc <= par_acc ^ link;
         end

         if (load) begin
            out_valid <= 1'b1;
            out_addr  <= pkt[PKT_W-1 -: ADDR_W];
            out_data  <= pkt[DATA_W-1:0];
         end else if (take) begin
            out_valid <= 1'b0;
         end

         perr <= bad_par;
         ovf  <= drop;

         if (drop && (drop_cnt != '1))
            drop_cnt <= drop_cnt + 1'b1;
         if (bad_par && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_serial_packet_rx.sv
// tb/tb_serial_packet_rx.sv - scoreboard bench for serial_packet_rx with directed packets
module tb_serial_packet_rx;

   logic       clock = 1'b0;
   logic       clear_n, link, out_ready;
   logic [1:0] rx_addr, rx_mask;
   logic       out_valid, perr, ovf;
   logic [1:0] out_addr;
   logic [3:0] out_data;
   logic [7:0] drop_cnt, err_cnt;
   logic       out_valid2, perr2, ovf2;
   logic [1:0] out_addr2, drop_cnt2, err_cnt2;
   logic [3:0] out_data2;

   int n_checks = 0, n_fail = 0;
   int perr_seen = 0, ovf_seen = 0, exp_perr_tot = 0, exp_ovf_tot = 0;
   int exp_err = 0, exp_err2 = 0, exp_drop = 0;
   logic [5:0] exp_q[$];
   logic [5:0] mon_e;

   serial_packet_rx dut (
      .clock(clock), .clear_n(clear_n), .link(link), .rx_addr(rx_addr), .rx_mask(rx_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
      .perr(perr), .ovf(ovf), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
   );

   serial_packet_rx #(.CNT_W(2)) dut_sat (
      .clock(clock), .clear_n(clear_n), .link(link), .rx_addr(rx_addr), .rx_mask(rx_mask),
      .out_valid(out_valid2), .out_ready(out_ready), .out_addr(out_addr2), .out_data(out_data2),
      .perr(perr2), .ovf(ovf2), .drop_cnt(drop_cnt2), .err_cnt(err_cnt2)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: inputs change just after posedge, so values seen at negedge are what the next edge uses.
   always @(negedge clock) begin
      if (clear_n) begin
         if (perr) perr_seen++;
         if (ovf) ovf_seen++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pkt: got addr %0d data %0d expected none", out_addr, out_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("pkt_addr", int'(out_addr), int'(mon_e[5:4]));
               chk("pkt_data", int'(out_data), int'(mon_e[3:0]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_pkt(input logic [1:0] a, input logic [3:0] d, input bit bad,
                           input bit acc, input bit exp_ovf, input bit rdy_last);
      logic [6:0] bits;
      bits = {a, d, (^{a, d}) ^ bad};
      link = 1'b1;
      tick();
      for (int i = 6; i >= 0; i--) begin
         link = bits[i];
         if (i == 0 && rdy_last) out_ready = 1'b1;
         tick();
      end
      link = 1'b0;
      chk("perr_pulse", int'(perr), int'(bad));
      chk("ovf_pulse", int'(ovf), int'(exp_ovf));
      if (bad) begin
         exp_perr_tot++;
         exp_err++;
         if (exp_err2 < 3) exp_err2++;
      end
      if (acc) begin
         if (exp_ovf) begin
            exp_ovf_tot++;
            exp_drop++;
         end else begin
            exp_q.push_back({a, d});
         end
         chk("valid_after_pkt", int'(out_valid), 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_n = 1'b0; link = 1'b0; out_ready = 1'b1; rx_addr = 2'b10; rx_mask = 2'b11;
      tick(); tick();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_addr", int'(out_addr), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_flags", int'({perr, ovf}), 0);
      chk("rst_cnts", int'({drop_cnt, err_cnt}), 0);
      clear_n = 1'b1;
      tick();

      send_pkt(2'b10, 4'hB, 0, 1, 0, 0);
      tick();
      chk("valid_one_cycle", int'(out_valid), 0);

      send_pkt(2'b10, 4'hB, 1, 0, 0, 0);
      chk("err_cnt_1", int'(err_cnt), exp_err);
      chk("no_valid_perr", int'(out_valid), 0);

      send_pkt(2'b01, 4'h9, 0, 0, 0, 0);
      chk("no_valid_filtered", int'(out_valid), 0);
      rx_mask = 2'b00;
      send_pkt(2'b01, 4'h6, 0, 1, 0, 0);
      tick(); tick();
      rx_mask = 2'b11;

      out_ready = 1'b0;
      send_pkt(2'b10, 4'h3, 0, 1, 0, 0);
      send_pkt(2'b10, 4'h5, 0, 1, 1, 0);
      chk("drop_cnt_1", int'(drop_cnt), exp_drop);
      chk("held_data", int'(out_data), 3);
      tick();
      chk("held_stable", int'(out_data), 3);
      out_ready = 1'b1;
      tick();
      chk("valid_drop_on_ready", int'(out_valid), 0);

      out_ready = 1'b0;
      send_pkt(2'b10, 4'h6, 0, 1, 0, 0);
      send_pkt(2'b10, 4'h7, 0, 1, 0, 1);
      chk("reload_data", int'(out_data), 7);
      tick(); tick();
      chk("valid_after_reload", int'(out_valid), 0);

      out_ready = 1'b0;
      send_pkt(2'b10, 4'hA, 0, 1, 0, 0);
      send_pkt(2'b10, 4'h1, 1, 0, 0, 0);
      link = 1'b1; tick();
      link = 1'b1; tick();
      link = 1'b0; tick();
      link = 1'b1; tick();
      clear_n = 1'b0;
      #1;
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_addr_data", int'({out_addr, out_data}), 0);
      chk("midrst_flags", int'({perr, ovf}), 0);
      chk("midrst_drop", int'(drop_cnt), 0);
      chk("midrst_err", int'(err_cnt), 0);
      chk("midrst_err_sat", int'(err_cnt2), 0);
      exp_q.delete();
      exp_err = 0; exp_err2 = 0; exp_drop = 0;
      link = 1'b0;
      tick();
      clear_n = 1'b1;
      out_ready = 1'b1;
      tick();

      send_pkt(2'b10, 4'hC, 0, 1, 0, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         send_pkt(2'b10, 4'(i), 1, 0, 0, 0);
         tick();
      end
      chk("err_cnt_5", int'(err_cnt), exp_err);
      chk("err_cnt_saturated", int'(err_cnt2), exp_err2);
      chk("drop_cnt_after_rst", int'(drop_cnt), exp_drop);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      chk("queue_drained", exp_q.size(), 0);
      chk("perr_total", perr_seen, exp_perr_tot);
      chk("ovf_total", ovf_seen, exp_ovf_tot);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
